// File: rtl/mp64_uart_tx_arb_pkg.sv
// Shared state encodings and constants for the UART TX arbiter.
package mp64_uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    UTX_IDLE  = 2'd0,
    UTX_START = 2'd1,
    UTX_DATA  = 2'd2,
    UTX_STOP  = 2'd3
  } utx_state_e;

  localparam int MP64_UART_BAUD_DEFAULT = 115_200;

  // Clock cycles per bit, rounded to nearest.
  function automatic int utx_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/mp64_uart_tx_arb_rr.sv
// mp64_rr_arbiter: combinational one-hot round-robin pick.
// Priority starts at the requester just after ptr and wraps.
module mp64_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] idx;

  // Walk farthest-to-nearest so the nearest hit wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = IW'((int'(ptr) + off) % NREQ);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/mp64_uart_tx_arb.sv
// Round-robin arbiter sharing one 8N1 UART TX pin among NREQ sources.
// Define MP64_UART_ARB_LOCK_EN to hold the grant until req_last.
module mp64_uart_tx_arb
  import mp64_uart_tx_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int CLOCK_HZ = 100_000_000,
  parameter int BAUD     = MP64_UART_BAUD_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*8-1:0]       req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    uart_txd,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [15:0]             tx_count
);

  localparam int DIV = utx_div(CLOCK_HZ, BAUD);
  localparam int TW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int IW  = $clog2(NREQ);
  localparam logic [TW-1:0] RELOAD = TW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("mp64_uart_tx_arb: DIV must be >= 2");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
    $error("mp64_uart_tx_arb: NREQ must be 2..8");
  end

  utx_state_e    state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, idx_n;
  logic [7:0]    shreg, sh_n;
  logic          txd_n;
  logic [IW-1:0] gid_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [15:0]   cnt_n;

  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   win;
  logic            fire;
  logic            tmr_zero;
  logic [7:0]      win_byte;

`ifdef MP64_UART_ARB_LOCK_EN
  logic          locked, locked_n;
  logic [IW-1:0] lock_id, lock_id_n;

  // While locked only the owner may be offered ready.
  always_comb begin
    cand = req_valid;
    if (locked) begin
      cand = req_valid & (NREQ'(1) << lock_id);
    end
  end

  always_comb begin
    locked_n  = locked;
    lock_id_n = lock_id;
    if (fire) begin
      locked_n  = ~req_last[win];
      lock_id_n = win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked  <= 1'b0;
      lock_id <= '0;
    end else begin
      locked  <= locked_n;
      lock_id <= lock_id_n;
    end
  end
`else
  logic unused_last;

  assign cand        = req_valid;
  assign unused_last = ^req_last;
`endif

  mp64_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req    (cand),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (win)
  );

  // Ready is suppressed during reset so nothing is consumed then.
  assign req_ready = (state == UTX_IDLE && !rst) ? gnt : '0;
  assign fire      = |req_ready;
  assign tmr_zero  = (timer == '0);
  assign win_byte  = req_data[{win, 3'b000} +: 8];
  assign busy      = (state != UTX_IDLE);

  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = bit_idx;
    sh_n    = shreg;
    txd_n   = uart_txd;
    gid_n   = grant_id;
    ptr_n   = ptr;
    cnt_n   = tx_count;
    if (state != UTX_IDLE) begin
      timer_n = tmr_zero ? RELOAD : timer - 1'b1;
    end
    unique case (state)
      UTX_IDLE: begin
        if (fire) begin
          state_n = UTX_START;
          timer_n = RELOAD;
          sh_n    = win_byte;
          txd_n   = 1'b0;
          gid_n   = win;
          ptr_n   = win;
        end
      end
      UTX_START: begin
        if (tmr_zero) begin
          state_n = UTX_DATA;
          idx_n   = 3'd0;
          txd_n   = shreg[0];
        end
      end
      UTX_DATA: begin
        if (tmr_zero) begin
          if (bit_idx == 3'd7) begin
            state_n = UTX_STOP;
            txd_n   = 1'b1;
          end else begin
            sh_n  = shreg >> 1;
            idx_n = bit_idx + 3'd1;
            txd_n = shreg[1];
          end
        end
      end
      UTX_STOP: begin
        if (tmr_zero) begin
          state_n = UTX_IDLE;
          cnt_n   = tx_count + 16'd1;
        end
      end
      default: state_n = UTX_IDLE;
    endcase
  end

  // Pointer resets to the last slot so requester 0 goes first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= UTX_IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      uart_txd <= 1'b1;
      grant_id <= '0;
      ptr      <= IW'(NREQ - 1);
      tx_count <= '0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      bit_idx  <= idx_n;
      shreg    <= sh_n;
      uart_txd <= txd_n;
      grant_id <= gid_n;
      ptr      <= ptr_n;
      tx_count <= cnt_n;
    end
  end

endmodule
